// File: rtl/core_eval_arbiter.sv
// core_eval_arbiter: round-robin front end that lets NREQ requesters share
// one combinational core. A granted requester's vector is registered onto
// core_in, held for SETTLE cycles, the core's result is captured and
// returned with the owner's index.
// Optional build macro: CORE_ARB_PARITY_EN adds rsp_par (XOR of rsp_data).
//
// Handshakes: a request transfers when req_valid[i] && req_ready[i] on a
// rising edge; a response transfers when rsp_valid && rsp_ready. Holders of
// valid keep their payload stable until the transfer; ready never waits
// on valid of the same channel's consumer.
module core_eval_arbiter #(
   parameter int NREQ   = 4,
   parameter int IN_W   = 14,
   parameter int OUT_W  = 8,
   parameter int SETTLE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*IN_W-1:0]     req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic [IN_W-1:0]          core_in,
   input  logic [OUT_W-1:0]         core_out,
   output logic                     rsp_valid,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [OUT_W-1:0]         rsp_data,
   input  logic                     rsp_ready,
   output logic                     busy,
`ifdef CORE_ARB_PARITY_EN
   output logic                     rsp_par,
`endif
   output logic [1:0]               dbg_state
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IN_W-1:0]   core_in_q, core_in_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [OUT_W-1:0]  data_q, data_d;
   logic [NREQ-1:0]   ready_c;
   logic              grant_any;
   logic [IDW-1:0]    grant_idx;
   logic [IDW-1:0]    idx;
`ifdef CORE_ARB_PARITY_EN
   logic              par_q, par_d;
`endif

   // Round-robin search starting just after the last granted index.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx;
         end
      end
   end

   // Next-state and datapath loads for the four-state controller.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      core_in_d = core_in_q;
      id_d      = id_q;
      data_d    = data_q;
      ready_c   = '0;
`ifdef CORE_ARB_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               ready_c[grant_idx] = 1'b1;
               core_in_d          = req_data[int'(grant_idx)*IN_W +: IN_W];
               id_d               = grant_idx;
               ptr_d              = grant_idx;
               cnt_d              = '0;
               state_d            = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == 4'(SETTLE - 1)) begin
               cnt_d   = '0;
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         CAPTURE: begin
            data_d  = core_out;
`ifdef CORE_ARB_PARITY_EN
            par_d   = ^core_out;
`endif
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= IDW'(NREQ - 1);
         cnt_q     <= '0;
         core_in_q <= '0;
         id_q      <= '0;
         data_q    <= '0;
`ifdef CORE_ARB_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         core_in_q <= core_in_d;
         id_q      <= id_d;
         data_q    <= data_d;
`ifdef CORE_ARB_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   // Reset gates the status outputs so an abandoned transaction never shows.
   assign req_ready = rst ? '0 : ready_c;
   assign rsp_valid = !rst && (state_q == RESP);
   assign busy      = !rst && (state_q != IDLE);
   assign core_in   = core_in_q;
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign dbg_state = state_q;
`ifdef CORE_ARB_PARITY_EN
   assign rsp_par   = par_q;
`endif

endmodule

// File: tb/tb_core_eval_arbiter.sv
// Bench for core_eval_arbiter: directed scenarios followed by random
// request/backpressure traffic against a round-robin reference model.
module tb_core_eval_arbiter;
   localparam int NREQ   = 4;
   localparam int IN_W   = 14;
   localparam int OUT_W  = 8;
   localparam int SETTLE = 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ*IN_W-1:0] req_data = '0;
   logic [NREQ-1:0]      req_ready;
   logic [IN_W-1:0]      core_in;
   logic [OUT_W-1:0]     core_out;
   logic                 rsp_valid;
   logic [1:0]           rsp_id;
   logic [OUT_W-1:0]     rsp_data;
   logic                 rsp_ready = 1'b1;
   logic                 busy;
   logic [1:0]           dbg_state;
`ifdef CORE_ARB_PARITY_EN
   logic                 rsp_par;
`endif

   int total = 0;
   int bad   = 0;
   int last_g = NREQ - 1;
   logic                 force_en = 1'b0;
   logic [OUT_W-1:0]     force_val = '0;

   // The shared core: an arbitrary fixed mixing function.
   function automatic logic [OUT_W-1:0] golden(input logic [IN_W-1:0] x);
      return (x[7:0] ^ {x[13:8], 2'b01}) + 8'h5A;
   endfunction

   assign core_out = force_en ? force_val : golden(core_in);

   core_eval_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .core_in(core_in), .core_out(core_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_ready(rsp_ready), .busy(busy),
`ifdef CORE_ARB_PARITY_EN
      .rsp_par(rsp_par),
`endif
      .dbg_state(dbg_state)
   );

   // Clock and reset block.
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: next grant is the first valid requester after the last one.
   function automatic int model_pick(input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last_g + k) % NREQ]) return (last_g + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic do_reset;
      rst = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      tick;
      tick;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_core_in", 32'(core_in), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
`ifdef CORE_ARB_PARITY_EN
      chk("rst_par", 32'(rsp_par), 32'd0);
`endif
      req_valid = '0;
      rst = 1'b0;
      last_g = NREQ - 1;
   endtask

   // One IDLE decision plus, if granted, the whole transaction with bp
   // cycles of response backpressure.
   task automatic run_txn(input int bp);
      int g;
      logic [IN_W-1:0]  exp_in;
      logic [OUT_W-1:0] exp_d;
      #1;
      g = model_pick(req_valid);
      if (g < 0) begin
         chk("idle_ready", 32'(req_ready), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         tick;
         return;
      end
      chk("grant", 32'(req_ready), 32'(1 << g));
      exp_in = req_data[g*IN_W +: IN_W];
      exp_d  = force_en ? force_val : golden(exp_in);
      last_g = g;
      tick;
      req_data  = NREQ*IN_W'({$urandom(), $urandom()});
      rsp_ready = (bp == 0);
      for (int i = 0; i <= SETTLE; i++) begin
         chk("run_busy", 32'(busy), 32'd1);
         chk("run_core_in", 32'(core_in), 32'(exp_in));
         chk("run_no_valid", 32'(rsp_valid), 32'd0);
         chk("run_no_ready", 32'(req_ready), 32'd0);
         tick;
      end
      for (int i = 0; i < bp; i++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_id", 32'(rsp_id), 32'(g));
         chk("bp_data", 32'(rsp_data), 32'(exp_d));
         chk("bp_no_ready", 32'(req_ready), 32'd0);
         tick;
      end
      rsp_ready = 1'b1;
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("rsp_data", 32'(rsp_data), 32'(exp_d));
`ifdef CORE_ARB_PARITY_EN
      chk("rsp_par", 32'(rsp_par), 32'(^exp_d));
`endif
      tick;
   endtask

   initial begin
      // Reset, then a single request from requester 0.
      do_reset;
      req_valid = 4'b0001;
      req_data[13:0] = 14'h2A5;
      #1;
      chk("single_grant", 32'(req_ready), 32'b0001);
      tick;
      req_valid = '0;
      tick;
      chk("single_c2", 32'(rsp_valid), 32'd0);
      tick;
      chk("single_c3_valid", 32'(rsp_valid), 32'd1);
      chk("single_c3_id", 32'(rsp_id), 32'd0);
      chk("single_c3_data", 32'(rsp_data), 32'(golden(14'h2A5)));
      tick;
      chk("single_done", 32'(busy), 32'd0);
      chk("core_in_kept", 32'(core_in), 32'h2A5);
      last_g = 0;

      // All four valid: grant order 0,1,2,3,0 every SETTLE+3 cycles.
      do_reset;
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         #1;
         chk("order", 32'(req_ready), 32'(1 << (n % NREQ)));
         run_txn(0);
      end

      // Backpressure for 10 cycles with everyone still requesting.
      run_txn(10);
      #1;
      chk("grant_after_bp", 32'(req_ready != 0), 32'd1);

      // Only requester 2: granted twice in a row via wrap search.
      req_valid = 4'b0100;
      run_txn(0);
      #1;
      chk("wrap_grant", 32'(req_ready), 32'b0100);
      run_txn(1);

      // Reset during DRIVE abandons the transaction.
      req_valid = 4'b0010;
      #1;
      chk("abort_grant", 32'(req_ready), 32'b0010);
      tick;
      chk("abort_drive", 32'(busy), 32'd1);
      rst = 1'b1;
      tick;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(rsp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      last_g = NREQ - 1;
      req_valid = 4'b1111;
      #1;
      chk("abort_first", 32'(req_ready), 32'b0001);
      run_txn(0);

`ifdef CORE_ARB_PARITY_EN
      force_en = 1'b1;
      force_val = 8'hB3;
      req_valid = 4'b0001;
      run_txn(0);
      chk("par_b3", 32'(rsp_par), 32'd1);
      force_val = 8'h81;
      run_txn(0);
      chk("par_81", 32'(rsp_par), 32'd0);
      force_en = 1'b0;
`endif

      // Random traffic.
      for (int n = 0; n < 60; n++) begin
         req_valid = NREQ'($urandom_range(0, 15));
         req_data  = NREQ*IN_W'({$urandom(), $urandom()});
         run_txn($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
